// File: rtl/chan_mux_arb_if.sv
// Handshake and data bundle for chan_mux_arb: N input channels muxed onto
// one registered output stream, plus the transfer counter.
interface chan_mux_arb_if #(
  parameter int W = 4,
  parameter int N = 4
) ();
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;
  logic [15:0]    xfer_cnt;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid, xfer_cnt
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid, xfer_cnt
  );
endinterface

// File: rtl/chan_mux_arb.sv
// N-channel mux into a single registered output beat; channel chosen by an
// external select (MODE=0) or by a rotating round-robin pointer (MODE=1).
module chan_mux_arb #(
  parameter int W    = 4,
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  chan_mux_arb_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q,   out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q,      ptr_d;
  logic [15:0]   xfer_cnt_q, xfer_cnt_d;

  logic          gnt_vld, hi_vld, lo_vld;
  logic [SW-1:0] gnt, hi_ch, lo_ch;
  logic          free, accept;
  logic [W-1:0]  gnt_data;
  logic [N-1:0]  rdy;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    hi_ch   = '0;
    hi_vld  = 1'b0;
    lo_ch   = '0;
    lo_vld  = 1'b0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < N; i++) begin
        if ((N == 1 || bus.sel == SW'(i)) && bus.in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt     = SW'(i);
        end
      end
    end else begin
      // Wrapping search split into two linear scans: at/above ptr first, then from 0.
      for (int unsigned i = 0; i < N; i++) begin
        if (!hi_vld && bus.in_valid[i] && i >= 32'(ptr_q)) begin
          hi_vld = 1'b1;
          hi_ch  = SW'(i);
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!lo_vld && bus.in_valid[i]) begin
          lo_vld = 1'b1;
          lo_ch  = SW'(i);
        end
      end
      gnt_vld = hi_vld || lo_vld;
      gnt     = hi_vld ? hi_ch : lo_ch;
    end
  end

  always_comb begin
    free     = !out_valid_q || bus.out_ready;
    accept   = rst_n && free && gnt_vld;
    gnt_data = '0;
    rdy      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt == SW'(i)) begin
        gnt_data = bus.in_data[i*W +: W];
        rdy[i]   = accept;
      end
    end

    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    ptr_d       = ptr_q;
    xfer_cnt_d  = xfer_cnt_q;
    if (out_valid_q && bus.out_ready) begin
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
    if (accept) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt;
      out_valid_d = 1'b1;
      if (MODE == 1) begin
        ptr_d = (32'(gnt) == N - 1) ? '0 : gnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.xfer_cnt  = xfer_cnt_q;
endmodule

// File: tb/tb_chan_mux_arb.sv
// Bench for chan_mux_arb: one MODE=0 and one MODE=1 instance share stimulus;
// a reference model predicts grants and a scoreboard checks every output beat.
module tb_chan_mux_arb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chan_mux_arb_if #(.W(4), .N(4)) i0 ();
  chan_mux_arb_if #(.W(4), .N(4)) i1 ();

  assign i0.in_data   = in_data;
  assign i0.in_valid  = in_valid;
  assign i0.sel       = sel;
  assign i0.out_ready = out_ready;
  assign i1.in_data   = in_data;
  assign i1.in_valid  = in_valid;
  assign i1.sel       = sel;
  assign i1.out_ready = out_ready;

  chan_mux_arb #(.W(4), .N(4), .MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  chan_mux_arb #(.W(4), .N(4), .MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

  logic [3:0]  rdy  [2];
  logic        ovl  [2];
  logic [3:0]  odat [2];
  logic [1:0]  och  [2];
  logic [15:0] cnt  [2];

  assign rdy[0]  = i0.in_ready;
  assign rdy[1]  = i1.in_ready;
  assign ovl[0]  = i0.out_valid;
  assign ovl[1]  = i1.out_valid;
  assign odat[0] = i0.out_data;
  assign odat[1] = i1.out_data;
  assign och[0]  = i0.out_ch;
  assign och[1]  = i1.out_ch;
  assign cnt[0]  = i0.xfer_cnt;
  assign cnt[1]  = i1.xfer_cnt;

  int         m_ptr [2];
  bit         m_ov  [2];
  int         m_cnt [2];
  logic [5:0] sb0 [$];
  logic [5:0] sb1 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs against the model, scoreboard any
  // output transfer, queue any accept, then advance the model past the edge.
  task automatic cycle();
    bit         acc [2];
    bit         xf  [2];
    int         g   [2];
    bit         gv;
    bit         free;
    int         idx;
    logic [3:0] er;
    logic [5:0] e;
    logic [5:0] obs;
    #1;
    for (int d = 0; d < 2; d++) begin
      free = !m_ov[d] || out_ready;
      gv   = 1'b0;
      g[d] = 0;
      if (d == 0) begin
        if (in_valid[sel]) begin
          gv   = 1'b1;
          g[d] = int'(sel);
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr[1] + k) % 4;
          if (!gv && in_valid[idx]) begin
            gv   = 1'b1;
            g[d] = idx;
          end
        end
      end
      acc[d] = rst_n && free && gv;
      er = '0;
      if (acc[d]) er[g[d]] = 1'b1;
      chk($sformatf("in_ready%0d", d), 32'(rdy[d]), 32'(er));
      chk($sformatf("out_valid%0d", d), 32'(ovl[d]), 32'(m_ov[d]));
      xf[d] = m_ov[d] && out_ready;
      if (xf[d]) begin
        obs = {och[d], odat[d]};
        if (d == 0) begin
          chk("sb_pending0", 32'(sb0.size() > 0), 32'd1);
          if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("beat0", 32'(obs), 32'(e));
          end
        end else begin
          chk("sb_pending1", 32'(sb1.size() > 0), 32'd1);
          if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("beat1", 32'(obs), 32'(e));
          end
        end
      end
      if (acc[d]) begin
        e = {2'(g[d]), in_data[g[d]*4 +: 4]};
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_ov[d]  = 1'b0;
        m_ptr[d] = 0;
        m_cnt[d] = 0;
        if (d == 0) sb0.delete();
        else        sb1.delete();
      end else begin
        if (xf[d]) m_cnt[d] = (m_cnt[d] + 1) & 32'hFFFF;
        if (acc[d]) begin
          m_ov[d] = 1'b1;
          if (d == 1) m_ptr[d] = (g[d] + 1) % 4;
        end else if (xf[d]) begin
          m_ov[d] = 1'b0;
        end
      end
      chk($sformatf("xfer_cnt%0d", d), 32'(cnt[d]), 32'(m_cnt[d]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    sel       = '0;
    out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0;
      m_ov[d]  = 1'b0;
      m_cnt[d] = 0;
    end
    @(posedge clk);
    #1;
    cycle();
    cycle();
    chk("rst_data", 32'(odat[1]), 32'h0);
    chk("rst_ch", 32'(och[1]), 32'h0);

    // external select picks ch2
    rst_n    = 1'b1;
    sel      = 2'd2;
    in_valid = 4'b0110;
    in_data  = 16'h3A51;
    cycle();
    chk("sel_valid", 32'(ovl[0]), 32'd1);
    chk("sel_data", 32'(odat[0]), 32'hA);
    chk("sel_ch", 32'(och[0]), 32'd2);

    // drain with no new accept: valid drops, data/ch hold
    out_ready = 1'b1;
    in_valid  = 4'b0000;
    cycle();
    chk("hold_data", 32'(odat[0]), 32'hA);
    chk("hold_ch", 32'(och[0]), 32'd2);

    // round-robin over all channels at full rate
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    in_data   = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_ch", 32'(och[1]), 32'(k % 4));
      chk("rr_cnt", 32'(cnt[1]), 32'(k));
    end

    // ptr=1 with ch0/ch3 requesting: ch3 first, then wrap to ch0
    in_valid = 4'b1001;
    cycle();
    chk("wrap_first", 32'(och[1]), 32'd3);
    cycle();
    chk("wrap_second", 32'(och[1]), 32'd0);

    // backpressure holds the ch0 beat while inputs churn
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_data = 16'($urandom);
      cycle();
      chk("bp_ch", 32'(och[1]), 32'd0);
      chk("bp_data", 32'(odat[1]), 32'h1);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_load", 32'(och[1]), 32'd1);

    // reset in the middle of a held beat
    rst_n = 1'b0;
    cycle();
    rst_n     = 1'b1;
    in_data   = 16'h8765;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (6) cycle();
    out_ready = 1'b0;
    cycle();
    chk("mid_cnt", 32'(cnt[1]), 32'd5);
    chk("mid_valid", 32'(ovl[1]), 32'd1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_ready", 32'(rdy[1]), 32'h0);
    chk("mid_rst_valid", 32'(ovl[1]), 32'd0);
    chk("mid_rst_data", 32'(odat[1]), 32'h0);
    chk("mid_rst_cnt", 32'(cnt[1]), 32'h0);

    // counter wrap after 65536 transfers
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (65536) cycle();
    chk("cnt_max", 32'(cnt[1]), 32'hFFFF);
    cycle();
    chk("cnt_wrap", 32'(cnt[1]), 32'h0);

    in_valid = 4'b0000;
    cycle();
    cycle();
    chk("drain1", 32'(sb1.size()), 32'd0);
    chk("drain0", 32'(sb0.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chan_mux_arb.md
CHAN_MUX_ARB -- requirements
Module: chan_mux_arb

Interface
REQ-001 Parameter W, default 4: data width per channel, in bits, at least 1.
REQ-002 Parameter N, default 4: number of input channels, at least 1.
REQ-003 Parameter MODE, default 0: selection mode; 0 = external select, 1 = round-robin arbitration.
REQ-004 Derived SW = max(1, clog2(N)): width of channel-index signals.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 in_data  input  N*W  packed channel data; channel i occupies bits [i*W+W-1 : i*W].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready; at most one bit set per cycle.
REQ-011 sel  input  SW  channel select, used only when MODE=0.
REQ-012 out_data  output  W  registered selected data.
REQ-013 out_ch  output  SW  index of the channel that sourced out_data.
REQ-014 out_valid  output  1  out_data/out_ch hold a valid beat.
REQ-015 out_ready  input  1  downstream accepts the beat.
REQ-016 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-017 Output register is free when (out_valid==0) or (out_ready==1); free is combinational.
REQ-018 MODE=0 grant: channel sel, if sel<N and in_valid[sel]==1; otherwise no grant.
REQ-019 MODE=1 grant: first channel with in_valid set, searching from ptr upward and wrapping N-1 to 0; no grant if in_valid==0.
REQ-020 in_ready[g] SHALL be 1 only when the output register is free and g is the granted channel; all other bits 0 (combinational).
REQ-021 An input beat is accepted when in_valid[g] and in_ready[g] are both 1; on that edge out_data<=channel g data, out_ch<=g, out_valid<=1.
REQ-022 Latency is 1 cycle from accept to out_valid; throughput is 1 beat/cycle when out_ready is held at 1.
REQ-023 If out_valid=1, out_ready=1 and no accept occurs, out_valid SHALL go to 0 and out_data/out_ch SHALL hold their values.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-025 If an output transfer and an accept occur in the same cycle, the new beat SHALL replace the old one with no bubble.
REQ-026 MODE=1: on accept from channel g, ptr<=(g+1) mod N; with no accept, ptr holds. MODE=0: ptr unused and held at 0.
REQ-027 xfer_cnt SHALL increment by 1 on each cycle with out_valid=1 and out_ready=1, and wrap from 65535 to 0.
REQ-028 With N=1, sel is ignored and channel 0 is always the candidate.
REQ-029 The block is lossless: data is neither dropped nor duplicated; a beat leaves exactly once.

Reset
REQ-030 When rst_n=0 at a rising edge: out_valid<=0, out_data<=0, out_ch<=0, ptr<=0, xfer_cnt<=0.
REQ-031 While rst_n=0, in_ready SHALL be all zeros.
REQ-032 Reset SHALL override any pending transfer or accept in the same cycle; a held beat is discarded.
REQ-033 Reset SHALL take effect at the next rising edge regardless of current state.

Verification (W=4, N=4)
REQ-034 MODE=0: sel=2, in_valid=4'b0110, ch2 data=4'hA, output empty -> in_ready=4'b0100; next cycle out_valid=1, out_data=4'hA, out_ch=2.
REQ-035 MODE=1: in_valid=4'b1111 and out_ready=1 held -> out_ch sequence 0,1,2,3,0 on consecutive cycles; xfer_cnt increments every cycle.
REQ-036 MODE=1: ptr=1, in_valid=4'b1001 -> channel 3 granted first, ptr=0, then channel 0 granted.
REQ-037 Backpressure: out_valid=1, out_ready=0 for 3 cycles with all in_valid set -> in_ready=0 and out_data/out_ch unchanged; first cycle with out_ready=1 -> new beat loaded, xfer_cnt+1.
REQ-038 Reset mid-operation: out_valid=1, out_ready=0, xfer_cnt=5, rst_n=0 for 1 cycle -> out_valid=0, out_data=0, xfer_cnt=0, in_ready=0 during reset.
REQ-039 Counter wrap: xfer_cnt=65535 plus one output transfer -> xfer_cnt=0.
